// File: rtl/mult_pkg.sv
// Shared types and constants for the run-skipping multiplier datapath.
// Optional build macro used by the slice: MULT_SIGNED_A_EN (signed multiplicand).
package mult_pkg;

  localparam int unsigned WIDTH_DEF      = 4;
  localparam int unsigned SHIFT_W        = 3;
  localparam int unsigned WATCHDOG_LIMIT = 2 * WIDTH_DEF + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  function automatic int unsigned watchdog_limit(input int unsigned width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/mult_acc.sv
// Accumulator for the shift/add multiplier: extends A, shifts it, and adds/subtracts/holds.
// Build macro: MULT_SIGNED_A_EN selects sign extension of A (zero extension otherwise).
module mult_acc
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic                 op_i,
  input  logic                 done_i,
  input  logic                 b_zero_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [2*WIDTH-1:0]   acc_next_o
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_q, acc_d;

`ifdef MULT_SIGNED_A_EN
  assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
`else
  assign a_ext = {{WIDTH{1'b0}}, a_i};
`endif

  assign addend = a_ext << shift_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      if (op_i) begin
        acc_d = acc_q + addend;
      end else if (!done_i && !b_zero_i) begin
        acc_d = acc_q - addend;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o      = acc_q;
  assign acc_next_o = acc_d;

endmodule

// File: rtl/mult_datapath.sv
// Operand/accumulator datapath and load/result handshake for the run-skipping multiplier.
// Build macro: MULT_SIGNED_A_EN makes A two's complement (signed product).
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 ready,
  output logic [WIDTH-1:0]     b_cur,
  output logic                 ctl_rst,
  input  logic [SHIFT_W-1:0]   a_shift_amount,
  input  logic [SHIFT_W-1:0]   b_shift_amount,
  input  logic                 op,
  input  logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid,
  input  logic                 product_ack,
  output logic                 err
);

  localparam int unsigned LIMIT = watchdog_limit(WIDTH);
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CNT_W-1:0]     step_cnt_q, step_cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 acc_clear;
  logic                 acc_step;
  logic                 b_zero;
  logic                 terminate;
  logic [2*WIDTH-1:0]   acc_cur;
  logic [2*WIDTH-1:0]   acc_next;

  assign b_zero    = (b_q == '0);
  assign terminate = done | (~op & b_zero);

  mult_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (acc_clear),
    .step_i     (acc_step),
    .op_i       (op),
    .done_i     (done),
    .b_zero_i   (b_zero),
    .a_i        (a_q),
    .shift_i    (a_shift_amount),
    .acc_o      (acc_cur),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    step_cnt_d = step_cnt_q;
    product_d  = product_q;
    valid_d    = valid_q;
    err_d      = err_q;
    acc_clear  = 1'b0;
    acc_step   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = a_in;
          b_d        = b_in;
          step_cnt_d = '0;
          err_d      = 1'b0;
          acc_clear  = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_step   = 1'b1;
        b_d        = b_q >> b_shift_amount;
        step_cnt_d = step_cnt_q + CNT_W'(1);
        // Result is captured from the accumulator's next value so the final step's update is included.
        if (terminate) begin
          product_d = acc_next;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end else if (step_cnt_q == CNT_W'(LIMIT - 1)) begin
          product_d = acc_next;
          err_d     = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (product_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      step_cnt_q <= '0;
      product_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      step_cnt_q <= step_cnt_d;
      product_q  <= product_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign ctl_rst       = (state_q != RUN);
  assign b_cur         = b_q;
  assign product       = product_q;
  assign product_valid = valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath paired with a behavioural run-skipping control unit.
module tb_mult_datapath;
  import mult_pkg::*;

  localparam int unsigned W = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic [W-1:0]       a_in;
  logic [W-1:0]       b_in;
  logic               ready;
  logic [W-1:0]       b_cur;
  logic               ctl_rst;
  logic [SHIFT_W-1:0] a_shift_amount;
  logic [SHIFT_W-1:0] b_shift_amount;
  logic               op;
  logic               done;
  logic [2*W-1:0]     product;
  logic               product_valid;
  logic               product_ack;
  logic               err;

  mult_datapath #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .a_in           (a_in),
    .b_in           (b_in),
    .ready          (ready),
    .b_cur          (b_cur),
    .ctl_rst        (ctl_rst),
    .a_shift_amount (a_shift_amount),
    .b_shift_amount (b_shift_amount),
    .op             (op),
    .done           (done),
    .product        (product),
    .product_valid  (product_valid),
    .product_ack    (product_ack),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control unit model: alternately skip a zero-run (subtract at run start) and a one-run (add at run end).
  logic               cu_in_run;
  logic [SHIFT_W-1:0] cu_pos;
  logic               m_op, m_done;
  logic [SHIFT_W-1:0] m_a, m_b;
  logic               use_stub;

  function automatic int tz(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int to(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (!v[i]) break;
      n++;
    end
    return n;
  endfunction

  always_comb begin
    int cnt;
    m_op   = 1'b0;
    m_done = 1'b0;
    m_a    = '0;
    m_b    = '0;
    cnt    = 0;
    if (cu_in_run) begin
      cnt    = to(b_cur);
      m_op   = 1'b1;
      m_done = ((int'(cu_pos) + cnt) == int'(W));
    end else begin
      cnt = tz(b_cur);
    end
    m_a = SHIFT_W'(int'(cu_pos) + cnt);
    m_b = SHIFT_W'(cnt);
  end

  always @(posedge clk) begin
    if (ctl_rst) begin
      cu_in_run <= 1'b0;
      cu_pos    <= '0;
    end else begin
      cu_in_run <= ~cu_in_run;
      cu_pos    <= cu_pos + m_b;
    end
  end

  assign op             = use_stub ? 1'b0 : m_op;
  assign done           = use_stub ? 1'b0 : m_done;
  assign a_shift_amount = use_stub ? '0   : m_a;
  assign b_shift_amount = use_stub ? '0   : m_b;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Caller must be at a negedge with ready=1; returns at negedge of RUN cycle 1.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    int k = 1;
    while (!product_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!product_valid) begin
      chk("valid_timeout", 32'(product_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    n = k - 1;
  endtask

  task automatic ack_txn();
    product_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    product_ack = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_u;
    logic [2*W-1:0] exp_s;
    int             n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    logic [2*W-1:0] exp_p;

    vecs[0] = '{a: 4'h5, b: 4'h6, exp_u: 8'h1E, exp_s: 8'h1E, n: 3};
    vecs[1] = '{a: 4'hF, b: 4'hF, exp_u: 8'hE1, exp_s: 8'hF1, n: 2};
    vecs[2] = '{a: 4'h9, b: 4'h0, exp_u: 8'h00, exp_s: 8'h00, n: 1};
    vecs[3] = '{a: 4'hD, b: 4'h7, exp_u: 8'h5B, exp_s: 8'hEB, n: 3};
    vecs[4] = '{a: 4'h3, b: 4'h5, exp_u: 8'h0F, exp_s: 8'h0F, n: 5};
    vecs[5] = '{a: 4'h7, b: 4'h8, exp_u: 8'h38, exp_s: 8'h38, n: 2};
    vecs[6] = '{a: 4'hF, b: 4'h9, exp_u: 8'h87, exp_s: 8'hF7, n: 4};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; product_ack = 1'b0; use_stub = 1'b0;
    #3;
    chk("rst_ready",   32'(ready),         32'd1);
    chk("rst_ctl_rst", 32'(ctl_rst),       32'd1);
    chk("rst_valid",   32'(product_valid), 32'd0);
    chk("rst_product", 32'(product),       32'd0);
    chk("rst_err",     32'(err),           32'd0);
    chk("rst_b_cur",   32'(b_cur),         32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
`ifdef MULT_SIGNED_A_EN
      exp_p = vecs[i].exp_s;
`else
      exp_p = vecs[i].exp_u;
`endif
      do_start(vecs[i].a, vecs[i].b);
      wait_valid(n);
      chk($sformatf("vec%0d_product", i), 32'(product), 32'(exp_p));
      chk($sformatf("vec%0d_steps", i),   32'(n),       32'(vecs[i].n));
      chk($sformatf("vec%0d_err", i),     32'(err),     32'd0);
      ack_txn();
      chk($sformatf("vec%0d_ready_after_ack", i), 32'(ready),         32'd1);
      chk($sformatf("vec%0d_valid_after_ack", i), 32'(product_valid), 32'd0);
      chk($sformatf("vec%0d_product_kept", i),    32'(product),       32'(exp_p));
    end

    // Hold with ignored start, then back-to-back start in the IDLE cycle after ack.
    do_start(4'h5, 4'h6);
    wait_valid(n);
    for (int c = 0; c < 3; c++) begin
      a_in = 4'h2; b_in = 4'h3; start = 1'b1;
      @(negedge clk);
      chk("hold_product", 32'(product),       32'h1E);
      chk("hold_valid",   32'(product_valid), 32'd1);
      chk("hold_ready",   32'(ready),         32'd0);
    end
    start = 1'b0;
    ack_txn();
    chk("b2b_idle_ready", 32'(ready), 32'd1);
    do_start(4'h3, 4'h5);
    chk("b2b_accepted", 32'(ready), 32'd0);
    wait_valid(n);
    chk("b2b_steps",   32'(n),       32'd5);
    chk("b2b_product", 32'(product), 32'h0F);
    ack_txn();

    // Asynchronous reset in the middle of RUN.
    do_start(4'h3, 4'h5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid",   32'(product_valid), 32'd0);
    chk("midrst_ready",   32'(ready),         32'd1);
    chk("midrst_ctl_rst", 32'(ctl_rst),       32'd1);
    chk("midrst_product", 32'(product),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_result", 32'(product_valid), 32'd0);
    chk("midrst_idle",      32'(ready),         32'd1);

    // Stuck control unit: watchdog fires after ten RUN cycles.
    use_stub = 1'b1;
    do_start(4'h1, 4'h1);
    repeat (9) @(negedge clk);
    chk("wd_err_cycle10",  32'(err),     32'd0);
    chk("wd_run_cycle10",  32'(ctl_rst), 32'd0);
    @(negedge clk);
    chk("wd_err_cycle11",  32'(err),     32'd1);
    chk("wd_hold_ctl_rst", 32'(ctl_rst), 32'd1);
    chk("wd_hold_ready",   32'(ready),   32'd0);
    ack_txn();
    use_stub = 1'b0;
    chk("wd_ack_ready", 32'(ready), 32'd1);

    do_start(4'h5, 4'h6);
    wait_valid(n);
    chk("post_wd_err",     32'(err),     32'd0);
    chk("post_wd_product", 32'(product), 32'h1E);
    ack_txn();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
